// File: rtl/uart_io_ctrl.sv
// CPU-facing UART register block: TX and RX byte FIFOs behind a registered
// IO decode (bit 12 = data port, bit 13 = status port), with a sticky TX overflow flag.

module uart_io_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_head,
   output logic             o_empty,
   output logic             o_full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   // A pop on an empty FIFO is ignored, so push+pop when empty is a plain push.
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end
endmodule

module uart_io_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [15:0] mem_addr,
   input  logic [15:0] dout,
   output logic [15:0] io_din,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);
   logic        r_io_rd;
   logic        r_io_wr;
   logic [15:0] r_dout;
   logic [15:0] r_addr;
   logic        r_tx_ovf;

   logic        w_sel_uart;
   logic        w_sel_stat;
   logic        w_tx_wr_req;
   logic        w_tx_pop;
   logic        w_tx_empty;
   logic        w_tx_full;
   logic        w_tx_ovf_evt;
   logic        w_stat_wr;
   logic        w_rx_push;
   logic        w_rx_pop;
   logic        w_rx_empty;
   logic        w_rx_full;
   logic [7:0]  w_rx_head;
   logic        w_unused_bits;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_io_rd <= 1'b0;
         r_io_wr <= 1'b0;
         r_dout  <= 16'd0;
         r_addr  <= 16'd0;
      end else begin
         r_io_rd <= io_rd;
         r_io_wr <= io_wr;
         r_dout  <= dout;
         if (io_rd || io_wr) r_addr <= mem_addr;
      end
   end

   // Data port takes precedence when both decode bits are set.
   assign w_sel_uart = r_addr[12];
   assign w_sel_stat = r_addr[13] & ~r_addr[12];

   assign w_tx_wr_req  = r_io_wr & w_sel_uart;
   assign w_tx_pop     = tx_valid & tx_ready;
   assign w_tx_ovf_evt = w_tx_wr_req & w_tx_full & ~w_tx_pop;
   assign w_stat_wr    = r_io_wr & w_sel_stat;

   uart_io_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk     (clk),
      .resetq  (resetq),
      .i_push  (w_tx_wr_req),
      .i_pop   (w_tx_pop),
      .i_din   (r_dout[7:0]),
      .o_head  (tx_data),
      .o_empty (w_tx_empty),
      .o_full  (w_tx_full)
   );

   assign tx_valid  = ~w_tx_empty;
   assign rx_ready  = ~w_rx_full;
   assign w_rx_push = rx_valid & rx_ready;
   assign w_rx_pop  = r_io_rd & w_sel_uart;

   uart_io_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk     (clk),
      .resetq  (resetq),
      .i_push  (w_rx_push),
      .i_pop   (w_rx_pop),
      .i_din   (rx_data),
      .o_head  (w_rx_head),
      .o_empty (w_rx_empty),
      .o_full  (w_rx_full)
   );

   // Overflow beats a same-edge status write so a dropped byte is never hidden.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_tx_ovf <= 1'b0;
      end else if (w_tx_ovf_evt) begin
         r_tx_ovf <= 1'b1;
      end else if (w_stat_wr) begin
         r_tx_ovf <= 1'b0;
      end
   end

   always_comb begin
      io_din = 16'd0;
      if (r_io_rd) begin
         if (w_sel_uart) begin
            io_din = {8'd0, w_rx_head};
         end else if (w_sel_stat) begin
            io_din = {12'd0, r_tx_ovf, w_tx_empty, ~w_tx_full, ~w_rx_empty};
         end
      end
   end

   assign w_unused_bits = ^{r_dout[15:8], r_addr[15:14], r_addr[11:0]};
endmodule

// File: tb/tb_uart_io_ctrl.sv
// Scoreboard bench for uart_io_ctrl: TX/RX byte queues plus a status model.

module tb_uart_io_ctrl;
   logic        clk;
   logic        resetq;
   logic        io_rd;
   logic        io_wr;
   logic [15:0] mem_addr;
   logic [15:0] dout;
   logic [15:0] io_din;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   int checks   = 0;
   int failures = 0;

   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic       exp_ovf = 1'b0;
   localparam int DEPTH = 4;

   uart_io_ctrl #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .resetq   (resetq),
      .io_rd    (io_rd),
      .io_wr    (io_wr),
      .mem_addr (mem_addr),
      .dout     (dout),
      .io_din   (io_din),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] status_model();
      return {12'd0, exp_ovf, (tx_q.size() == 0), (tx_q.size() < DEPTH), (rx_q.size() != 0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic io_write(input logic [15:0] a, input logic [15:0] d);
      tick();
      io_wr = 1'b1; mem_addr = a; dout = d;
      tick();
      io_wr = 1'b0;
   endtask

   task automatic io_read(input logic [15:0] a, output logic [15:0] d);
      tick();
      io_rd = 1'b1; mem_addr = a;
      tick();
      io_rd = 1'b0;
      d = io_din;
   endtask

   task automatic test_reset();
      logic [15:0] d;
      resetq = 1'b0;
      tick();
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'd0 || rx_ready !== 1'b1 || io_din !== 16'd0) begin
         failures++;
         $display("FAIL reset_outputs: got tv=%b td=%h rr=%b din=%h want 0 00 1 0000",
                  tx_valid, tx_data, rx_ready, io_din);
      end
      tick();
      resetq = 1'b1;
      io_read(16'h2000, d);
      checks++;
      if (d !== status_model()) begin
         failures++;
         $display("FAIL reset_status: got %h want %h", d, status_model());
      end
      $display("test_reset status=%h", d);
   endtask

   task automatic test_single_byte();
      tx_ready = 1'b0;
      tick();
      io_wr = 1'b1; mem_addr = 16'h1000; dout = 16'h0041;
      tx_q.push_back(8'h41);
      tick();
      io_wr = 1'b0;
      checks++;
      if (tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_n1_valid: got %b want 0", tx_valid);
      end
      tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== tx_q[0]) begin
         failures++;
         $display("FAIL single_n2_data: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, tx_q[0]);
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      void'(tx_q.pop_front());
      checks++;
      if (tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_drained: got %b want 0", tx_valid);
      end
      $display("test_single_byte tx=41 done");
   endtask

   task automatic test_tx_overflow();
      logic [15:0] d;
      tx_ready = 1'b0;
      for (int b = 1; b <= 5; b++) begin
         io_write(16'h1000, 16'(b));
         if (tx_q.size() < DEPTH) tx_q.push_back(8'(b));
         else exp_ovf = 1'b1;
      end
      io_read(16'h2000, d);
      checks++;
      if (d !== status_model() || d !== 16'h0008) begin
         failures++;
         $display("FAIL ovf_status: got %h want %h", d, status_model());
      end
      io_write(16'h2000, 16'h0000);
      exp_ovf = 1'b0;
      io_read(16'h2000, d);
      checks++;
      if (d !== status_model()) begin
         failures++;
         $display("FAIL ovf_clear: got %h want %h", d, status_model());
      end
      for (int i = 0; i < 8 && tx_q.size() != 0; i++) begin
         tx_ready = 1'b1;
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== tx_q[0]) begin
            failures++;
            $display("FAIL ovf_drain: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, tx_q[0]);
         end
         $display("test_tx_overflow drain %h", tx_data);
         void'(tx_q.pop_front());
         tick();
      end
      tx_ready = 1'b0;
      checks++;
      if (tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL ovf_empty: got %b want 0", tx_valid);
      end
      io_read(16'h2000, d);
      checks++;
      if (d !== status_model()) begin
         failures++;
         $display("FAIL ovf_final_status: got %h want %h", d, status_model());
      end
   endtask

   task automatic test_rx_fill();
      logic [15:0] d;
      rx_valid = 1'b1;
      rx_data  = 8'h10;
      for (int i = 0; i < 8; i++) begin
         if (rx_q.size() == DEPTH) break;
         checks++;
         if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL rx_accept: got rx_ready=%b want 1", rx_ready);
         end
         rx_q.push_back(rx_data);
         tick();
         rx_data = rx_data + 8'd1;
      end
      tick();
      checks++;
      if (rx_ready !== (rx_q.size() < DEPTH)) begin
         failures++;
         $display("FAIL rx_full: got rx_ready=%b want %b", rx_ready, rx_q.size() < DEPTH);
      end
      rx_valid = 1'b0;
      io_read(16'h2000, d);
      checks++;
      if (d !== status_model()) begin
         failures++;
         $display("FAIL rx_status: got %h want %h", d, status_model());
      end
      io_read(16'h4000, d);
      checks++;
      if (d !== 16'h0000) begin
         failures++;
         $display("FAIL rx_unmapped: got %h want 0000", d);
      end
      io_read(16'h3000, d);
      checks++;
      if (d !== {8'd0, rx_q[0]}) begin
         failures++;
         $display("FAIL rx_both_bits: got %h want %h", d, {8'd0, rx_q[0]});
      end
      void'(rx_q.pop_front());
      for (int i = 0; i < 8 && rx_q.size() != 0; i++) begin
         io_read(16'h1000, d);
         checks++;
         if (d !== {8'd0, rx_q[0]}) begin
            failures++;
            $display("FAIL rx_read: got %h want %h", d, {8'd0, rx_q[0]});
         end
         $display("test_rx_fill read %h", d);
         void'(rx_q.pop_front());
      end
      tick();
      rx_valid = 1'b1;
      rx_data  = 8'h14;
      checks++;
      if (rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL rx_refill_ready: got %b want 1", rx_ready);
      end
      rx_q.push_back(rx_data);
      tick();
      rx_valid = 1'b0;
      io_read(16'h1000, d);
      checks++;
      if (d !== {8'd0, rx_q[0]}) begin
         failures++;
         $display("FAIL rx_last: got %h want %h", d, {8'd0, rx_q[0]});
      end
      void'(rx_q.pop_front());
   endtask

   task automatic test_empty_read();
      logic [15:0] d;
      io_read(16'h1000, d);
      checks++;
      if (d !== 16'h0000) begin
         failures++;
         $display("FAIL empty_read: got %h want 0000", d);
      end
      tick();
      checks++;
      if (io_din !== 16'h0000) begin
         failures++;
         $display("FAIL idle_din: got %h want 0000", io_din);
      end
      io_read(16'h2000, d);
      checks++;
      if (d !== status_model()) begin
         failures++;
         $display("FAIL empty_status: got %h want %h", d, status_model());
      end
      $display("test_empty_read status=%h", d);
   endtask

   task automatic test_back_to_back();
      logic [15:0] d;
      logic [7:0]  last;
      last = 8'h00;
      tx_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         io_write(16'h1000, 16'h0050 + 16'(i));
         tx_q.push_back(8'h50 + 8'(i));
      end
      tick();
      io_wr = 1'b1; mem_addr = 16'h1000; dout = 16'h00AA;
      tick();
      io_wr = 1'b0;
      tx_ready = 1'b1;
      checks++;
      if (tx_data !== tx_q[0]) begin
         failures++;
         $display("FAIL b2b_head: got %h want %h", tx_data, tx_q[0]);
      end
      void'(tx_q.pop_front());
      tx_q.push_back(8'hAA);
      tick();
      tx_ready = 1'b0;
      io_read(16'h2000, d);
      checks++;
      if (d !== status_model()) begin
         failures++;
         $display("FAIL b2b_status: got %h want %h", d, status_model());
      end
      for (int i = 0; i < 8 && tx_q.size() != 0; i++) begin
         tx_ready = 1'b1;
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== tx_q[0]) begin
            failures++;
            $display("FAIL b2b_drain: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, tx_q[0]);
         end
         $display("test_back_to_back drain %h", tx_data);
         last = tx_data;
         void'(tx_q.pop_front());
         tick();
      end
      tx_ready = 1'b0;
      checks++;
      if (last !== 8'hAA) begin
         failures++;
         $display("FAIL b2b_last: got %h want aa", last);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] d;
      tx_ready = 1'b0;
      io_write(16'h1000, 16'h0061);
      io_write(16'h1000, 16'h0062);
      rx_valid = 1'b1; rx_data = 8'h71;
      tick();
      rx_data = 8'h72;
      tick();
      rx_valid = 1'b0;
      resetq = 1'b0;
      io_wr = 1'b1; mem_addr = 16'h1000; dout = 16'h0077;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'd0 || rx_ready !== 1'b1 || io_din !== 16'd0) begin
         failures++;
         $display("FAIL midreset_outputs: got tv=%b td=%h rr=%b din=%h want 0 00 1 0000",
                  tx_valid, tx_data, rx_ready, io_din);
      end
      tick();
      io_wr = 1'b0;
      tick();
      resetq = 1'b1;
      tx_q.delete();
      rx_q.delete();
      exp_ovf = 1'b0;
      tick();
      tick();
      checks++;
      if (tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_pending: got tx_valid=%b want 0", tx_valid);
      end
      io_read(16'h2000, d);
      checks++;
      if (d !== status_model()) begin
         failures++;
         $display("FAIL midreset_status: got %h want %h", d, status_model());
      end
      $display("test_reset_mid status=%h", d);
   endtask

   initial begin
      resetq = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
      mem_addr = 16'd0; dout = 16'd0;
      tx_ready = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
      test_reset();
      test_single_byte();
      test_tx_overflow();
      test_rx_fill();
      test_empty_read();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
